// File: rtl/serializador_if.sv
// serializador_if: parallel-in / serial-out bus of the serializador; SERIAL_STATS_EN adds the word counter.
interface serializador_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic enqueue_in;
  logic ack_out;
  logic busy_in;
  logic data_out;
  logic write_out;
  logic status_out;
`ifdef SERIAL_STATS_EN
  logic [15:0] words_sent_out;
  modport slave(input data_in, enqueue_in, busy_in,
                output ack_out, data_out, write_out, status_out, words_sent_out);
  modport master(output data_in, enqueue_in, busy_in,
                 input ack_out, data_out, write_out, status_out, words_sent_out);
`else
  modport slave(input data_in, enqueue_in, busy_in,
                output ack_out, data_out, write_out, status_out);
  modport master(output data_in, enqueue_in, busy_in,
                 input ack_out, data_out, write_out, status_out);
`endif
endinterface

// File: rtl/serializador.sv
// serializador: double-buffered MSB-first word serializer with busy stall; SERIAL_STATS_EN adds words_sent_out.
module serializador #(
  parameter int WIDTH = 8
) (
  input logic clock_100KHz,
  input logic reset,
  serializador_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state_q;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0] bit_cnt_q;
  logic hold_full_q;
  logic ack_q;
  logic data_q;
  logic write_q;
`ifdef SERIAL_STATS_EN
  logic [15:0] sent_q;
  assign bus.words_sent_out = sent_q;
`endif
  assign bus.ack_out = ack_q;
  assign bus.data_out = data_q;
  assign bus.write_out = write_q;
  assign bus.status_out = hold_full_q;
  // Accept needs hold_full_q=0 and transfer needs it 1, so their writes to hold_full_q never collide.
  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q <= '0;
      shift_q <= '0;
      bit_cnt_q <= '0;
      hold_full_q <= 1'b0;
      ack_q <= 1'b0;
      data_q <= 1'b0;
      write_q <= 1'b0;
`ifdef SERIAL_STATS_EN
      sent_q <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      if (bus.enqueue_in && !hold_full_q) begin
        hold_q <= bus.data_in;
        hold_full_q <= 1'b1;
        ack_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          write_q <= 1'b0;
          if (hold_full_q && !bus.busy_in) begin
            shift_q <= hold_q;
            hold_full_q <= 1'b0;
            bit_cnt_q <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          write_q <= !bus.busy_in;
          if (!bus.busy_in) begin
            data_q <= shift_q[WIDTH-1];
            shift_q <= shift_q << 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CW'(WIDTH - 1)) begin
              state_q <= GAP;
`ifdef SERIAL_STATS_EN
              sent_q <= sent_q + 16'd1;
`endif
            end
          end
        end
        GAP: begin
          write_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serializador.md
Name: serializador

Overview:
- Transmit-side counterpart of the deserializer: takes parallel words from the local side and shifts them out MSB-first as a serial bit stream.
- Each serial bit is qualified by a write strobe, so its output pair can drive a deserializer's data_in/write_in pair directly.
- Contains a one-word holding register (double buffering): the next word is accepted while the current word is still shifting.
- Honours a downstream busy/status line by stalling.

Parameters:
- WIDTH, 8, word width in bits; also the number of serial bits per word.

Ports:
- clock_100KHz  input  1  bit clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word to transmit.
- enqueue_in  input  1  word-valid request; sampled every edge.
- ack_out  output  1  one-cycle pulse: word captured into the holding register.
- busy_in  input  1  downstream busy (deserializer status_out); 1 = stall.
- data_out  output  1  serial bit, registered.
- write_out  output  1  serial bit valid, registered.
- status_out  output  1  1 = holding register full, new words refused.

Behaviour:
- Reset (synchronous, active-high): state IDLE, hold_full=0, bit_cnt=0.
  - Outputs after reset: ack_out=0, data_out=0, write_out=0, status_out=0.
  - Reset mid-word discards both the shifting word and the held word; no ack is issued for anything in flight.
- Accept:
  - At an edge with enqueue_in=1 and hold_full=0: hold<=data_in, hold_full<=1, ack_out<=1 for exactly one cycle.
  - enqueue_in while hold_full=1 is ignored: no ack, data not captured. The requester holds the request until it sees ack_out.
  - status_out = hold_full (registered). It rises in the cycle after the accept edge.
- FSM states IDLE, SHIFT, GAP:
  - IDLE:
    - If hold_full=1 and busy_in=0: shift<=hold, hold_full<=0, bit_cnt<=0, go SHIFT.
    - write_out=0 in IDLE.
    - An accept cannot coincide with a transfer, because accept requires hold_full=0 at the sampled edge.
  - SHIFT, each edge:
    - If busy_in=0: data_out<=shift[WIDTH-1], write_out<=1, shift<=shift<<1, bit_cnt<=bit_cnt+1.
    - If busy_in=1: write_out<=0, and shift, bit_cnt and data_out hold (stall; no bit lost or duplicated).
    - When the WIDTH-th bit is emitted (bit_cnt==WIDTH-1 and busy_in=0), go GAP.
  - GAP: write_out<=0, go IDLE. Exactly one gap cycle.
- Latency:
  - Accept at edge E0, transfer at E1, bits valid after edges E2..E(WIDTH+1), write_out low after E(WIDTH+2).
- Throughput with no stalls:
  - One word per WIDTH+2 cycles.
  - write_out low for exactly 2 cycles between consecutive words (GAP and IDLE transfer).
- Hold register refill:
  - hold is free again from E1.
  - A new word may be acked while the previous word shifts, so back-to-back traffic never starves.
- bit_cnt width is $clog2(WIDTH)+1 and never wraps mid-word.

Optional Feature:
- Macro: SERIAL_STATS_EN.
- Defined:
  - Adds output words_sent_out, 16 bits, reset 0.
  - Increments by 1 on each transition from SHIFT to GAP. Wraps 16'hFFFF -> 0.
  - Not incremented for words killed by reset.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
- Reset, then enqueue 8'hA5 once, busy_in=0 -> ack_out pulses 1 cycle after E0; write_out=1 for 8 consecutive cycles with data_out 1,0,1,0,0,1,0,1; status_out 1 for one cycle then 0.
- Enqueue 8'hF0 and 8'h0F back-to-back, enqueue_in held high -> second ack one cycle after transfer of the first word; serial stream 11110000, 2 low-write_out cycles, 00001111; no word lost.
- Send 8'h81 and raise busy_in for 3 cycles after the 2nd bit -> write_out=0 for exactly those 3 cycles; bit sequence still 10000001, total 8 valid bits.
- busy_in=1 before enqueue of 8'h3C -> ack still issued, status_out=1, no write_out until busy_in drops; then 00111100 emitted.
- Assert reset after the 4th bit of 8'hFF with 8'h11 held -> next cycle all outputs 0, status_out=0; after release, enqueue 8'h11 -> only 00010001 emitted (with SERIAL_STATS_EN: words_sent_out=1).
